// File: rtl/isqrt_pkg.sv
// Shared widths, FSM state type and the legal resolve-rate list for the
// sequential integer square-root responder.
package isqrt_pkg;

    localparam int X_W   = 32;
    localparam int Y_W   = 16;
    localparam int REM_W = Y_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } isqrt_state_t;

    localparam int N_LEGAL_IPC = 5;
    localparam int LEGAL_IPC [N_LEGAL_IPC] = '{1, 2, 4, 8, 16};

    function automatic bit ipc_is_legal(input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_IPC; i++) begin
            if (LEGAL_IPC[i] == v) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings down the next
// radicand bit pair and resolves one root bit.  Purely combinational.
module isqrt_step
    import isqrt_pkg::*;
(
    input  logic [REM_W-1:0] i_rem,
    input  logic [Y_W-1:0]   i_root,
    input  logic [X_W-1:0]   i_x_sh,
    output logic [REM_W-1:0] o_rem,
    output logic [Y_W-1:0]   o_root,
    output logic [X_W-1:0]   o_x_sh
);

    logic [REM_W-1:0] w_rem_sh;
    logic [REM_W-1:0] w_trial;
    logic             w_fits;

    assign w_rem_sh = {i_rem[REM_W-3:0], i_x_sh[X_W-1:X_W-2]};
    assign w_trial  = {i_root, 2'b01};
    assign w_fits   = (w_rem_sh >= w_trial);

    assign o_rem  = w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
    assign o_root = {i_root[Y_W-2:0], w_fits};
    assign o_x_sh = {i_x_sh[X_W-3:0], 2'b00};

    // The recurrence shifts the two remainder MSBs out; they never carry information.
    logic w_unused_rem_msb;
    assign w_unused_rem_msb = &{1'b0, i_rem[REM_W-1:REM_W-2]};

endmodule

// File: rtl/isqrt_seq.sv
// Multi-cycle floor(sqrt(x)) responder with fixed, data-independent latency
// of 16/ITER_PER_CYCLE + 1 cycles from acceptance to y_vld.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [X_W-1:0] x,
    output logic           y_vld,
    output logic [Y_W-1:0] y,
    output logic           busy,
    output logic           drop
);

    localparam int N_CYC = 16 / ITER_PER_CYCLE;
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;

    generate
        if (!ipc_is_legal(ITER_PER_CYCLE)) begin : g_bad_ipc
            $error("isqrt_seq: ITER_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    isqrt_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [REM_W-1:0] r_rem;
    logic [Y_W-1:0]   r_root;
    logic [X_W-1:0]   r_x_sh;
    logic [Y_W-1:0]   r_y;
    logic             r_y_vld;
    logic             r_drop;

    logic [REM_W-1:0] w_rem  [ITER_PER_CYCLE+1];
    logic [Y_W-1:0]   w_root [ITER_PER_CYCLE+1];
    logic [X_W-1:0]   w_x_sh [ITER_PER_CYCLE+1];
    logic             w_cnt_last;

    assign w_rem[0]  = r_rem;
    assign w_root[0] = r_root;
    assign w_x_sh[0] = r_x_sh;

    // ITER_PER_CYCLE iterations chained combinationally between the registers.
    for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_step
        isqrt_step u_step (
            .i_rem  (w_rem[k]),
            .i_root (w_root[k]),
            .i_x_sh (w_x_sh[k]),
            .o_rem  (w_rem[k+1]),
            .o_root (w_root[k+1]),
            .o_x_sh (w_x_sh[k+1])
        );
    end

    assign w_cnt_last = (r_cnt == CNT_W'(N_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_x_sh  <= '0;
            r_y     <= '0;
            r_y_vld <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_y_vld <= 1'b0;
            r_drop  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (x_vld) begin
                        r_state <= BUSY;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_x_sh  <= x;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    r_rem  <= w_rem[ITER_PER_CYCLE];
                    r_root <= w_root[ITER_PER_CYCLE];
                    r_x_sh <= w_x_sh[ITER_PER_CYCLE];
                    r_drop <= x_vld;
                    if (w_cnt_last) begin
                        r_state <= DONE;
                        r_y     <= w_root[ITER_PER_CYCLE];
                        r_y_vld <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign y_vld = r_y_vld;
    assign y     = r_y;
    assign busy  = (r_state == BUSY);
    assign drop  = r_drop;

endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: directed corners/protocol cases on
// ITER_PER_CYCLE=1 instances and concurrent random sweeps at 2, 4 and 16.
module tb_isqrt_seq;

    localparam int NI    = 5;
    localparam int NCORN = 7;
    localparam int NRAND = 2000;

    typedef struct {
        logic [15:0] y;
        int          due;
    } exp_t;

    function automatic int ipc_of(input int i);
        case (i)
            0, 1:    return 1;
            2:       return 2;
            3:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return 16 / ipc_of(i) + 1;
    endfunction

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (longint'(t) * longint'(t) <= longint'(v)) r = t;
        end
        return r;
    endfunction

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          sweep_go = 1'b0;
    bit          sweep_done [NI];

    logic        rst_a   [NI];
    logic        x_vld_a [NI];
    logic [31:0] x_a     [NI];
    logic        y_vld_a [NI];
    logic [15:0] y_a     [NI];
    logic        busy_a  [NI];
    logic        drop_a  [NI];
    exp_t        sb      [NI][$];

    logic [31:0] corn_x [NCORN] = '{32'd0, 32'd1, 32'd15, 32'd16,
                                    32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
    logic [15:0] corn_y [NCORN] = '{16'd0, 16'd1, 16'd3, 16'd4,
                                    16'hFFFF, 16'hFFFF, 16'hFFFE};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        isqrt_seq #(.ITER_PER_CYCLE(ipc_of(g))) u_dut (
            .clk   (clk),
            .rst   (rst_a[g]),
            .x_vld (x_vld_a[g]),
            .x     (x_a[g]),
            .y_vld (y_vld_a[g]),
            .y     (y_a[g]),
            .busy  (busy_a[g]),
            .drop  (drop_a[g])
        );
    end

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [31:0] v, input logic [15:0] e, input bit expect_it);
        x_a[i]     = v;
        x_vld_a[i] = 1'b1;
        if (expect_it) sb[i].push_back('{y: e, due: cyc + lat_of(i)});
        tick();
        x_vld_a[i] = 1'b0;
        x_a[i]     = 'x;
    endtask

    task automatic wait_vld(input int i);
        for (int k = 0; k < 40 && !y_vld_a[i]; k++) tick();
        check($sformatf("vld_wait%0d", i), y_vld_a[i], 1);
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 40 && sb[i].size() != 0; k++) tick();
        check($sformatf("drain%0d", i), sb[i].size(), 0);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_mon
        exp_t e;
        always @(negedge clk) begin
            if (y_vld_a[g]) begin
                check($sformatf("result_pending%0d", g), (sb[g].size() > 0), 1);
                if (sb[g].size() > 0) begin
                    e = sb[g].pop_front();
                    check($sformatf("y%0d", g), y_a[g], e.y);
                    check($sformatf("latency%0d", g), cyc, e.due);
                end
            end
        end
    end

    for (genvar g = 2; g < NI; g++) begin : g_sweep
        initial begin
            logic [31:0] v;
            sweep_done[g] = 1'b0;
            wait (sweep_go);
            tick();
            for (int n = 0; n < NCORN + NRAND; n++) begin
                v = (n < NCORN) ? corn_x[n] : $urandom();
                if (n > 0) wait_vld(g);
                req(g, v, ref_sqrt(v), 1'b1);
            end
            wait_idle(g);
            sweep_done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_a[i]   = 1'b1;
            x_vld_a[i] = 1'b0;
            x_a[i]     = '0;
        end
        repeat (3) tick();
        for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
        check("rst_y_vld", y_vld_a[0], 0);
        check("rst_y", y_a[0], 0);
        check("rst_busy", busy_a[0], 0);
        check("rst_drop", drop_a[0], 0);
        sweep_go = 1'b1;

        for (int c = 0; c < NCORN; c++) begin
            req(0, corn_x[c], corn_y[c], 1'b1);
            wait_idle(0);
        end

        // Back-to-back: second request issued in the DONE cycle.
        req(0, 32'd100, 16'd10, 1'b1);
        wait_vld(0);
        req(0, 32'd2, 16'd1, 1'b1);
        check("b2b_busy", busy_a[0], 1);
        wait_idle(0);

        // Request while busy is dropped and leaves the running result intact.
        req(0, 32'd81, 16'd9, 1'b1);
        repeat (4) tick();
        x_a[0]     = 32'd49;
        x_vld_a[0] = 1'b1;
        tick();
        x_vld_a[0] = 1'b0;
        check("drop_pulse", drop_a[0], 1);
        tick();
        check("drop_clear", drop_a[0], 0);
        wait_idle(0);
        repeat (20) tick();
        check("drop_y_hold", y_a[0], 9);

        // Parallel instances issued together must finish together.
        x_a[0] = 32'h0001_0000;
        x_a[1] = 32'h1234_5678;
        x_vld_a[0] = 1'b1;
        x_vld_a[1] = 1'b1;
        sb[0].push_back('{y: 16'd256, due: cyc + lat_of(0)});
        sb[1].push_back('{y: 16'h4444, due: cyc + lat_of(1)});
        tick();
        x_vld_a[0] = 1'b0;
        x_vld_a[1] = 1'b0;
        wait_vld(0);
        check("par_sync", y_vld_a[1], 1);
        wait_idle(0);
        wait_idle(1);

        // Reset in the middle of a computation.
        req(0, 32'h4000_0000, 16'd0, 1'b0);
        repeat (7) tick();
        rst_a[0] = 1'b1;
        tick();
        rst_a[0] = 1'b0;
        check("rst_mid_busy", busy_a[0], 0);
        check("rst_mid_y", y_a[0], 0);
        repeat (20) tick();
        check("rst_mid_y_after", y_a[0], 0);
        req(0, 32'd9, 16'd3, 1'b1);
        wait_idle(0);

        for (int k = 0; k < 40000 && !(sweep_done[2] && sweep_done[3] && sweep_done[4]); k++) tick();
        check("sweep_complete", (sweep_done[2] && sweep_done[3] && sweep_done[4]), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
